// File: rtl/map_mem_arbiter_if.sv
// Playfield map access bundle: renderer read port, game read/write port, clear control.
// Latency: none here; signal grouping only.
// Backpressure: game side waits on game_gnt; renderer and clear control have none.
interface map_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 6
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_stale;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic [DATA_W-1:0] game_rdata;
  logic              game_rvalid;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  // Requesters: renderer, game engine and whoever triggers map clears.
  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, clr_start,
    input  disp_data, disp_valid, disp_stale, game_gnt, game_rdata, game_rvalid,
    input  clr_busy, clr_done
  );

  // The arbiter owning the map storage.
  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata, clr_start,
    output disp_data, disp_valid, disp_stale, game_gnt, game_rdata, game_rvalid,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/map_mem_arbiter.sv
// Snake playfield cell map behind one single-port storage; renderer has priority, game does read-modify-write, sweep clears.
// Latency: display/game read data registered one cycle after request/grant; game writes commit at the end of the grant cycle.
// Backpressure: game_gnt low while the renderer reads or a sweep runs; MAP_ARB_STARVE_GUARD_EN forces a grant after GAME_WAIT_MAX waits.
module map_mem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 6,
  parameter int CLEAR_VAL     = 0,
  parameter int GAME_WAIT_MAX = 16
) (
  input logic              clk,
  input logic              reset_n,
  map_mem_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
  logic              clr_done_q, clr_done_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              disp_stale_q, disp_stale_d;
  logic [DATA_W-1:0] game_rdata_q, game_rdata_d;
  logic              game_rvalid_q, game_rvalid_d;

  logic              game_gnt;
  logic              starve_win;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(GAME_WAIT_MAX + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // A game request that has waited GAME_WAIT_MAX cycles wins over the renderer.
  always_comb begin
    starve_win = (state_q == ST_RUN) && bus.game_req && (wait_cnt_q == WAIT_W'(GAME_WAIT_MAX));
  end

  // Count consecutive RUN cycles in which a pending game request is refused.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ST_RUN) && bus.game_req && !game_gnt) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  // Renderer always wins; no forced game grant.
  always_comb begin
    starve_win = 1'b0;
  end
`endif

  // Game grant: never during a sweep, otherwise only when the renderer is idle (or starvation forces it).
  always_comb begin
    game_gnt = (state_q == ST_RUN) && bus.game_req && (!bus.disp_req || starve_win);
  end

  // Single storage port: sweep write in CLEAR, otherwise the granted game access or the renderer read.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = sweep_addr_q;
    mem_wdata = DATA_W'(CLEAR_VAL);
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (game_gnt) begin
      mem_addr  = bus.game_addr;
      mem_we    = bus.game_we;
      mem_wdata = bus.game_wdata;
    end else begin
      mem_addr = bus.disp_addr;
    end
  end

  assign mem_rdata = mem_q[mem_addr];

  // Map storage; contents are not reset, the sweep initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Next state, sweep progress and registered responses.
  always_comb begin
    state_d       = state_q;
    sweep_addr_d  = sweep_addr_q;
    clr_done_d    = 1'b0;
    disp_data_d   = disp_data_q;
    disp_valid_d  = 1'b0;
    disp_stale_d  = 1'b0;
    game_rdata_d  = game_rdata_q;
    game_rvalid_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == {ADDR_W{1'b1}}) begin
          state_d      = ST_RUN;
          clr_done_d   = 1'b1;
          sweep_addr_d = '0;
        end
        // The map is being blanked, so renderer sees empty cells.
        if (bus.disp_req) begin
          disp_data_d  = DATA_W'(CLEAR_VAL);
          disp_valid_d = 1'b1;
        end
      end
      default: begin
        if (bus.clr_start) begin
          state_d      = ST_CLEAR;
          sweep_addr_d = '0;
        end
        if (game_gnt && !bus.game_we) begin
          game_rdata_d  = mem_rdata;
          game_rvalid_d = 1'b1;
        end
        // When the game took the port, the renderer gets its previous data flagged stale.
        if (bus.disp_req) begin
          disp_valid_d = 1'b1;
          if (starve_win) disp_stale_d = 1'b1;
          else            disp_data_d  = mem_rdata;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_CLEAR;
      sweep_addr_q  <= '0;
      clr_done_q    <= 1'b0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      disp_stale_q  <= 1'b0;
      game_rdata_q  <= '0;
      game_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_addr_q  <= sweep_addr_d;
      clr_done_q    <= clr_done_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      disp_stale_q  <= disp_stale_d;
      game_rdata_q  <= game_rdata_d;
      game_rvalid_q <= game_rvalid_d;
    end
  end

  assign bus.disp_data   = disp_data_q;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_stale  = disp_stale_q;
  assign bus.game_gnt    = game_gnt;
  assign bus.game_rdata  = game_rdata_q;
  assign bus.game_rvalid = game_rvalid_q;
  assign bus.clr_busy    = (state_q == ST_CLEAR);
  assign bus.clr_done    = clr_done_q;
endmodule

// File: tb/tb_map_mem_arbiter.sv
// Bench for map_mem_arbiter: directed scenarios plus randomized traffic against a cell-array reference model.
// Latency: checks registered responses one cycle after each request/grant.
// Backpressure: game master holds its request stable until the grant is seen.
module tb_map_mem_arbiter;
  localparam int AW       = 8;
  localparam int DW       = 6;
  localparam int DEPTH    = 256;
  localparam int WAIT_MAX = 16;
`ifdef MAP_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  int unsigned   model_mem [DEPTH];
  logic [DW-1:0] exp_disp_data;
  logic [DW-1:0] exp_game_rdata;

  map_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  map_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_VAL(0), .GAME_WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.disp_req  = 1'b0;
    bus.game_req  = 1'b0;
    bus.game_we   = 1'b0;
    bus.clr_start = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
  endtask

  // Outputs that must hold their reset values while reset_n is low.
  task automatic check_reset_outputs(input string tag);
    checks++; if (bus.disp_data !== '0)      begin errors++; $display("FAIL %s disp_data: got %0d expected 0", tag, bus.disp_data); end
    checks++; if (bus.disp_valid !== 1'b0)   begin errors++; $display("FAIL %s disp_valid: got %0b expected 0", tag, bus.disp_valid); end
    checks++; if (bus.disp_stale !== 1'b0)   begin errors++; $display("FAIL %s disp_stale: got %0b expected 0", tag, bus.disp_stale); end
    checks++; if (bus.game_rdata !== '0)     begin errors++; $display("FAIL %s game_rdata: got %0d expected 0", tag, bus.game_rdata); end
    checks++; if (bus.game_rvalid !== 1'b0)  begin errors++; $display("FAIL %s game_rvalid: got %0b expected 0", tag, bus.game_rvalid); end
    checks++; if (bus.game_gnt !== 1'b0)     begin errors++; $display("FAIL %s game_gnt: got %0b expected 0", tag, bus.game_gnt); end
    checks++; if (bus.clr_busy !== 1'b1)     begin errors++; $display("FAIL %s clr_busy: got %0b expected 1", tag, bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0)     begin errors++; $display("FAIL %s clr_done: got %0b expected 0", tag, bus.clr_done); end
  endtask

  // Runs from the first busy cycle until the sweep ends; optionally re-pulses clr_start mid-sweep.
  task automatic sweep_and_check(input string tag, input int pulse_at);
    int n;
    n = 0;
    bus.game_req  = 1'b1;
    bus.game_we   = 1'b0;
    bus.game_addr = AW'($urandom);
    while (bus.clr_busy === 1'b1 && n < 1000) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'($urandom);
      bus.clr_start = (n == pulse_at);
      #1;
      checks++; if (bus.game_gnt !== 1'b0) begin errors++; $display("FAIL %s gnt_in_clear: got %0b expected 0 (cycle %0d)", tag, bus.game_gnt, n); end
      checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL %s done_early: got %0b expected 0 (cycle %0d)", tag, bus.clr_done, n); end
      step();
      n++;
      checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== '0 || bus.disp_stale !== 1'b0) begin
        errors++; $display("FAIL %s disp_in_clear: got v=%0b d=%0d s=%0b expected v=1 d=0 s=0", tag, bus.disp_valid, bus.disp_data, bus.disp_stale);
      end
    end
    drive_idle();
    exp_disp_data = '0;
    model_clear();
    checks++; if (n != 256) begin errors++; $display("FAIL %s busy_cycles: got %0d expected 256", tag, n); end
    checks++; if (bus.clr_done !== 1'b1) begin errors++; $display("FAIL %s done_pulse: got %0b expected 1", tag, bus.clr_done); end
    step();
    checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %0b expected 0", tag, bus.clr_done); end
  endtask

  // Pipelined renderer reads of every cell compared against the model.
  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'(i);
      step();
      checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== DW'(model_mem[i])) begin
        errors++; $display("FAIL %s cell %0d: got v=%0b d=%0d expected v=1 d=%0d", tag, i, bus.disp_valid, bus.disp_data, model_mem[i]);
      end
    end
    exp_disp_data = DW'(model_mem[DEPTH-1]);
    bus.disp_req = 1'b0;
    step();
    checks++; if (bus.disp_valid !== 1'b0 || bus.disp_data !== exp_disp_data) begin
      errors++; $display("FAIL %s idle_hold: got v=%0b d=%0d expected v=0 d=%0d", tag, bus.disp_valid, bus.disp_data, exp_disp_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    bus.disp_addr  = '0;
    bus.game_addr  = '0;
    bus.game_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    exp_game_rdata = '0;
    sweep_and_check("reset_sweep", -1);
    read_all("post_reset");
  endtask

  task automatic test_write_then_disp();
    bus.disp_req   = 1'b0;
    bus.game_req   = 1'b1;
    bus.game_we    = 1'b1;
    bus.game_addr  = 8'h23;
    bus.game_wdata = 6'd42;
    #1;
    checks++; if (bus.game_gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: got %0b expected 1", bus.game_gnt); end
    step();
    model_mem[8'h23] = 42;
    bus.game_req  = 1'b0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 8'h23;
    step();
    checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== 6'd42) begin
      errors++; $display("FAIL raw_disp: got v=%0b d=%0d expected v=1 d=42", bus.disp_valid, bus.disp_data);
    end
    checks++; if (bus.game_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %0b expected 0", bus.game_rvalid); end
    bus.disp_req = 1'b0;
    step();
    exp_disp_data = 6'd42;
    checks++; if (bus.disp_valid !== 1'b0 || bus.disp_data !== 6'd42) begin
      errors++; $display("FAIL disp_hold: got v=%0b d=%0d expected v=0 d=42", bus.disp_valid, bus.disp_data);
    end
  endtask

  task automatic test_contention();
    bus.disp_addr = 8'h05;
    bus.game_req  = 1'b1;
    bus.game_we   = 1'b0;
    bus.game_addr = 8'h23;
    for (int c = 0; c < 3; c++) begin
      bus.disp_req = 1'b1;
      #1;
      checks++; if (bus.game_gnt !== 1'b0) begin errors++; $display("FAIL contend_gnt c%0d: got %0b expected 0", c, bus.game_gnt); end
      step();
      checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== DW'(model_mem[5]) || bus.game_rvalid !== 1'b0) begin
        errors++; $display("FAIL contend_disp c%0d: got v=%0b d=%0d rv=%0b expected v=1 d=%0d rv=0", c, bus.disp_valid, bus.disp_data, bus.game_rvalid, model_mem[5]);
      end
    end
    bus.disp_req = 1'b0;
    #1;
    checks++; if (bus.game_gnt !== 1'b1) begin errors++; $display("FAIL contend_gnt4: got %0b expected 1", bus.game_gnt); end
    step();
    checks++; if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 6'd42) begin
      errors++; $display("FAIL contend_read: got rv=%0b rd=%0d expected rv=1 rd=42", bus.game_rvalid, bus.game_rdata);
    end
    bus.game_req = 1'b0;
    step();
    exp_game_rdata = 6'd42;
    exp_disp_data  = DW'(model_mem[5]);
    checks++; if (bus.game_rvalid !== 1'b0 || bus.game_rdata !== 6'd42) begin
      errors++; $display("FAIL rdata_hold: got rv=%0b rd=%0d expected rv=0 rd=42", bus.game_rvalid, bus.game_rdata);
    end
  endtask

  task automatic test_starve();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 8'h05;
    bus.game_req  = 1'b1;
    bus.game_we   = 1'b0;
    bus.game_addr = 8'h23;
`ifdef MAP_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= WAIT_MAX + 1; c++) begin
      if (c == WAIT_MAX + 1) bus.disp_addr = 8'h23;
      #1;
      checks++; if (bus.game_gnt !== (c == WAIT_MAX + 1)) begin
        errors++; $display("FAIL starve_gnt c%0d: got %0b expected %0b", c, bus.game_gnt, (c == WAIT_MAX + 1));
      end
      step();
    end
    checks++; if (bus.disp_valid !== 1'b1 || bus.disp_stale !== 1'b1 || bus.disp_data !== DW'(model_mem[5])) begin
      errors++; $display("FAIL starve_stale: got v=%0b s=%0b d=%0d expected v=1 s=1 d=%0d", bus.disp_valid, bus.disp_stale, bus.disp_data, model_mem[5]);
    end
    checks++; if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== DW'(model_mem[8'h23])) begin
      errors++; $display("FAIL starve_read: got rv=%0b rd=%0d expected rv=1 rd=%0d", bus.game_rvalid, bus.game_rdata, model_mem[8'h23]);
    end
`else
    for (int c = 1; c <= 100; c++) begin
      #1;
      checks++; if (bus.game_gnt !== 1'b0) begin errors++; $display("FAIL no_guard_gnt c%0d: got %0b expected 0", c, bus.game_gnt); end
      step();
      checks++; if (bus.disp_stale !== 1'b0) begin errors++; $display("FAIL no_guard_stale c%0d: got %0b expected 0", c, bus.disp_stale); end
    end
`endif
    exp_disp_data  = DW'(model_mem[5]);
    exp_game_rdata = DW'(model_mem[8'h23]);
    drive_idle();
    step();
  endtask

  task automatic test_random_traffic(input int cycles);
    int   waited;
    bit   pend;
    logic exp_gnt, exp_dv, exp_rv, exp_stale;
    waited = 0;
    pend   = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend           = 1'b1;
        bus.game_we    = 1'($urandom);
        bus.game_addr  = AW'($urandom);
        bus.game_wdata = DW'($urandom);
      end
      bus.game_req  = pend;
      bus.disp_req  = ($urandom_range(0, 3) != 0);
      bus.disp_addr = AW'($urandom);
      #1;
      exp_gnt = pend && (!bus.disp_req || (GUARD && waited == WAIT_MAX));
      checks++; if (bus.game_gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %0b expected %0b", c, bus.game_gnt, exp_gnt); end
      exp_stale = exp_gnt && bus.disp_req;
      waited    = (pend && !exp_gnt) ? waited + 1 : 0;
      exp_dv    = bus.disp_req;
      exp_rv    = exp_gnt && !bus.game_we;
      if (exp_rv) exp_game_rdata = DW'(model_mem[bus.game_addr]);
      if (bus.disp_req && !exp_stale) exp_disp_data = DW'(model_mem[bus.disp_addr]);
      if (exp_gnt && bus.game_we) model_mem[bus.game_addr] = bus.game_wdata;
      if (exp_gnt) pend = 1'b0;
      step();
      checks++; if (bus.disp_valid !== exp_dv || bus.disp_data !== exp_disp_data || bus.disp_stale !== exp_stale) begin
        errors++; $display("FAIL rand_disp c%0d: got v=%0b d=%0d s=%0b expected v=%0b d=%0d s=%0b", c,
                           bus.disp_valid, bus.disp_data, bus.disp_stale, exp_dv, exp_disp_data, exp_stale);
      end
      checks++; if (bus.game_rvalid !== exp_rv || bus.game_rdata !== exp_game_rdata) begin
        errors++; $display("FAIL rand_game c%0d: got rv=%0b rd=%0d expected rv=%0b rd=%0d", c, bus.game_rvalid, bus.game_rdata, exp_rv, exp_game_rdata);
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_clear_restart();
    bus.disp_req  = 1'b0;
    bus.clr_start = 1'b1;
    bus.game_req  = 1'b1;
    bus.game_we   = 1'b0;
    bus.game_addr = 8'h23;
    #1;
    checks++; if (bus.game_gnt !== 1'b1) begin errors++; $display("FAIL clr_sample_gnt: got %0b expected 1", bus.game_gnt); end
    exp_game_rdata = DW'(model_mem[8'h23]);
    step();
    checks++; if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== exp_game_rdata || bus.clr_busy !== 1'b1) begin
      errors++; $display("FAIL clr_sample_read: got rv=%0b rd=%0d busy=%0b expected rv=1 rd=%0d busy=1", bus.game_rvalid, bus.game_rdata, bus.clr_busy, exp_game_rdata);
    end
    bus.clr_start = 1'b0;
    sweep_and_check("clear_restart", 10);
    read_all("post_clear");
  endtask

  task automatic test_reset_mid_sweep();
    bus.game_req   = 1'b1;
    bus.game_we    = 1'b1;
    bus.game_addr  = 8'h07;
    bus.game_wdata = 6'd9;
    step();
    bus.game_we = 1'b0;
    step();
    checks++; if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 6'd9) begin
      errors++; $display("FAIL pre_abort_read: got rv=%0b rd=%0d expected rv=1 rd=9", bus.game_rvalid, bus.game_rdata);
    end
    bus.game_req  = 1'b0;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = AW'($urandom);
      step();
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    exp_game_rdata = '0;
    sweep_and_check("sweep_after_abort", -1);
    read_all("post_abort");
  endtask

  initial begin
    test_reset();
    test_write_then_disp();
    test_contention();
    test_starve();
    test_random_traffic(400);
    test_clear_restart();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/map_mem_arbiter.md
# map_mem_arbiter

Owns the snake playfield map storage (one 6-bit cell code per grid position) and sequences every access to it through a single port. It sits between the game engine (read-modify-write of cells) and the VGA renderer (continuous cell lookups). The renderer gets priority. A built-in sweep sequencer clears the map after reset and on demand.

## Interface

Parameters:
- ADDR_W, 8: cell index width; depth is 2^ADDR_W cells.
- DATA_W, 6: cell code width; codes 0–63.
- CLEAR_VAL, 0: code written by the clear sweep (empty cell).
- GAME_WAIT_MAX, 16: starvation limit; used only with the macro.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_req  in  1  renderer read request.
- disp_addr  in  ADDR_W  renderer cell index.
- disp_data  out  DATA_W  renderer read data.
- disp_valid  out  1  disp_data holds the response to the previous cycle's request.
- disp_stale  out  1  response is the held previous value, not a fresh read.
- game_req  in  1  game access request.
- game_we  in  1  1 = write, 0 = read.
- game_addr  in  ADDR_W  game cell index.
- game_wdata  in  DATA_W  game write data.
- game_gnt  out  1  combinational grant; the access transfers when game_req && game_gnt.
- game_rdata  out  DATA_W  game read data.
- game_rvalid  out  1  game_rdata is valid (one-cycle pulse).
- clr_start  in  1  request a full-map clear.
- clr_busy  out  1  clear sweep is in progress.
- clr_done  out  1  one-cycle pulse when a sweep finishes.

## Operation

- Storage is 2^ADDR_W × DATA_W with exactly one access (read or write) per cycle.
- FSM has two states, CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - Writes CLEAR_VAL to addresses 0, 1, … 2^ADDR_W−1, one address per cycle.
  - clr_busy=1 and game_gnt=0 throughout.
  - Display requests are answered with CLEAR_VAL, disp_valid=1, disp_stale=0.
  - clr_start is ignored.
  - In the cycle after the last address is written, the FSM moves to RUN and clr_done pulses.
- RUN:
  - Arbitration priority, highest first: clr_start, then disp_req, then game_req.
  - clr_start sampled high moves the FSM to CLEAR on the next cycle. Arbitration in the sampling cycle is unaffected.
  - game_gnt = game_req && !disp_req (when the macro is defined, also granted per Configuration).
  - The game master holds game_we, game_addr and game_wdata stable until granted.
- Read-after-write: a write transferred in cycle N is visible to any read issued in cycle N+1 or later.
- Addresses are full-width; there is no out-of-range case.

## Timing

- Display read:
  - Request in cycle N.
  - disp_data and disp_valid are registered at N+1.
  - disp_valid=0 in any cycle after a cycle with no disp_req.
  - disp_data holds its last value when not valid.
- Game write: commits at the end of the grant cycle.
- Game read:
  - Granted in cycle N.
  - game_rdata and game_rvalid are registered at N+1.
  - game_rdata holds its value otherwise.
- Clear sweep:
  - clr_start sampled in RUN cycle N gives clr_busy=1 from N+1.
  - The sweep takes 2^ADDR_W cycles (256 by default).
  - clr_done pulses in the first RUN cycle.
- Reset values:
  - disp_data=0, disp_valid=0, disp_stale=0.
  - game_rdata=0, game_rvalid=0, game_gnt=0.
  - clr_busy=1, clr_done=0.
  - Sweep address=0, wait counter=0.
- Reset asserted mid-sweep or mid-access aborts the operation immediately. A new sweep starts from address 0 after release. A write in flight at reset is not guaranteed to have committed.

## Configuration

- Macro: MAP_ARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter of width clog2(GAME_WAIT_MAX+1) increments on each RUN cycle with game_req && !game_gnt.
  - The counter clears on a grant, when game_req is low, or in CLEAR.
  - When the counter equals GAME_WAIT_MAX and game_req is high, game_gnt=1 even if disp_req is high.
  - The display request in that cycle is answered at N+1 with the previous disp_data, disp_valid=1 and disp_stale=1.
- Undefined:
  - The counter is absent.
  - The display always wins.
  - disp_stale is tied to 0.

## Test plan

- Reset release → clr_busy=1 for 256 cycles; clr_done pulses once at cycle 256 after release; a read of any address afterwards returns 0.
- RUN, disp_req=0, game write addr 0x23 data 42 → game_gnt=1 in the same cycle; display read of 0x23 in the next cycle → disp_data=42, disp_valid=1 one cycle later.
- disp_req and game_req (read 0x23) both high for 3 cycles, then disp_req=0 → game_gnt=0 for 3 cycles; grant on cycle 4; game_rdata=42, game_rvalid=1 on cycle 5.
- RUN after several writes, pulse clr_start, pulse it again 10 cycles later → 256 busy cycles (the second pulse is ignored); game_gnt=0 throughout; all cells read 0 afterwards.
- Assert reset_n low at sweep address 100 → outputs return to their reset values immediately; after release the sweep restarts at 0 and takes the full 256 cycles.
- With MAP_ARB_STARVE_GUARD_EN, disp_req and game_req held high → game_gnt=1 on the 17th cycle and disp_stale=1 the following cycle. Without the macro → game_gnt stays 0 for 100 cycles.
